mem_dram_cycle_ctrl: RTL

//  DRAM cycle controller on MEM/ADDR, directly upstream of the row/column address mux.

---
 rtl/mem_cyc_pkg.sv | 25 ++
 rtl/mem_cyc_refresh_timer.sv | 31 +++
 rtl/mem_dram_cycle_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_cyc_pkg.sv
// Shared state encoding and default DRAM timing constants for the cycle controller
// and the RAM sheet models.
package mem_cyc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LATCH   = 3'd1,
    ST_ROW     = 3'd2,
    ST_COLSU   = 3'd3,
    ST_COL     = 3'd4,
    ST_PRE     = 3'd5,
    ST_REF_CAS = 3'd6,
    ST_REF_RAS = 3'd7
  } mem_cyc_state_e;

  localparam int unsigned RAS_CAS_CYC_DEF  = 2;
  localparam int unsigned CAS_CYC_DEF      = 2;
  localparam int unsigned PRE_CYC_DEF      = 2;
  localparam int unsigned REF_INTERVAL_DEF = 234;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_cyc_refresh_timer.sv
// Free-running refresh interval timer: one-cycle tick every REF_INTERVAL cycles.
// Only generated when MEM_CYC_REFRESH_TIMER_EN is defined.
`ifdef MEM_CYC_REFRESH_TIMER_EN
module mem_cyc_refresh_timer #(
  parameter int unsigned REF_INTERVAL = 234
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned TW = $clog2(REF_INTERVAL + 1);
  localparam logic [TW-1:0] RELOAD = TW'(REF_INTERVAL - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= RELOAD;
      tick <= 1'b0;
    end else if (cnt == '0) begin
      cnt  <= RELOAD;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt - TW'(1);
      tick <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/mem_dram_cycle_ctrl.sv
// DRAM cycle controller: access/CBR-refresh sequencing and row/column mux enables.
// Optional internal refresh timer enabled by MEM_CYC_REFRESH_TIMER_EN.
module mem_dram_cycle_ctrl
  import mem_cyc_pkg::*;
#(
  parameter int unsigned RAS_CAS_CYC  = RAS_CAS_CYC_DEF,
  parameter int unsigned CAS_CYC      = CAS_CYC_DEF,
  parameter int unsigned PRE_CYC      = PRE_CYC_DEF
`ifdef MEM_CYC_REFRESH_TIMER_EN
  ,
  parameter int unsigned REF_INTERVAL = REF_INTERVAL_DEF
`endif
) (
  input  logic sysclk,
  input  logic sys_rst,
  input  logic MREQ,
  input  logic WRITE,
  input  logic REFRQ,
  output logic BCGNT50,
  output logic LOEN_n,
  output logic HIEN_n,
  output logic RAS_n,
  output logic CAS_n,
  output logic WE_n,
  output logic MACK,
  output logic REFACK,
  output logic BUSY
);

  localparam int unsigned CW = $clog2(max2(RAS_CAS_CYC + CAS_CYC, PRE_CYC) + 1);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t ROW_LD = cnt_t'(RAS_CAS_CYC - 1);
  localparam cnt_t COL_LD = cnt_t'(CAS_CYC - 1);
  localparam cnt_t PRE_LD = cnt_t'(PRE_CYC - 1);
  localparam cnt_t REF_LD = cnt_t'(RAS_CAS_CYC + CAS_CYC - 1);

  mem_cyc_state_e state, nxt_state;
  cnt_t           cnt, nxt_cnt;
  logic           wr_cap, nxt_wr;
  logic           ref_pend, ref_req, ref_start;

`ifdef MEM_CYC_REFRESH_TIMER_EN
  logic tmr_tick;

  mem_cyc_refresh_timer #(
    .REF_INTERVAL(REF_INTERVAL)
  ) u_refresh_timer (
    .clk (sysclk),
    .rst (sys_rst),
    .tick(tmr_tick)
  );

  assign ref_req = REFRQ | tmr_tick;
`else
  assign ref_req = REFRQ;
`endif

  // A request arriving in the same IDLE cycle is consumed directly, so refresh still wins over MREQ.
  assign ref_start = (state == ST_IDLE) && (ref_pend || ref_req);

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_wr    = wr_cap;
    unique case (state)
      ST_IDLE: begin
        if (ref_start) begin
          nxt_state = ST_REF_CAS;
          nxt_cnt   = '0;
        end else if (MREQ) begin
          nxt_state = ST_LATCH;
          nxt_cnt   = '0;
          nxt_wr    = WRITE;
        end
      end
      ST_LATCH: begin
        nxt_state = ST_ROW;
        nxt_cnt   = ROW_LD;
      end
      ST_ROW: begin
        if (cnt != '0) nxt_cnt = cnt - cnt_t'(1);
        else begin
          nxt_state = ST_COLSU;
          nxt_cnt   = '0;
        end
      end
      ST_COLSU: begin
        nxt_state = ST_COL;
        nxt_cnt   = COL_LD;
      end
      ST_COL: begin
        if (cnt != '0) nxt_cnt = cnt - cnt_t'(1);
        else begin
          nxt_state = ST_PRE;
          nxt_cnt   = PRE_LD;
        end
      end
      ST_PRE: begin
        if (cnt != '0) nxt_cnt = cnt - cnt_t'(1);
        else nxt_state = ST_IDLE;
      end
      ST_REF_CAS: begin
        nxt_state = ST_REF_RAS;
        nxt_cnt   = REF_LD;
      end
      ST_REF_RAS: begin
        if (cnt != '0) nxt_cnt = cnt - cnt_t'(1);
        else begin
          nxt_state = ST_PRE;
          nxt_cnt   = PRE_LD;
        end
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so each one is registered yet aligned with its state.
  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      wr_cap   <= 1'b0;
      ref_pend <= 1'b0;
      BCGNT50  <= 1'b0;
      LOEN_n   <= 1'b1;
      HIEN_n   <= 1'b1;
      RAS_n    <= 1'b1;
      CAS_n    <= 1'b1;
      WE_n     <= 1'b1;
      MACK     <= 1'b0;
      REFACK   <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      wr_cap   <= nxt_wr;
      ref_pend <= ref_start ? 1'b0 : (ref_pend | ref_req);
      BCGNT50  <= (nxt_state == ST_LATCH);
      LOEN_n   <= !(nxt_state == ST_ROW);
      HIEN_n   <= !(nxt_state == ST_COLSU || nxt_state == ST_COL);
      RAS_n    <= !(nxt_state == ST_ROW || nxt_state == ST_COLSU || nxt_state == ST_REF_RAS);
      CAS_n    <= !(nxt_state == ST_COL || nxt_state == ST_REF_CAS || nxt_state == ST_REF_RAS);
      WE_n     <= !(nxt_state == ST_COL && nxt_wr);
      MACK     <= (nxt_state == ST_COL) && (nxt_cnt == '0);
      REFACK   <= (nxt_state == ST_REF_RAS) && (nxt_cnt == '0);
      BUSY     <= (nxt_state != ST_IDLE);
    end
  end

endmodule
